hub75_scan_ctrl: RTL and testbench
==================================

// Module: hub75_scan_ctrl
// PURPOSE
//  Bus-mapped HUB75 LED-panel controller. Replaces CPU bit-banging through parallel_output.
//  Holds a frame buffer the CPU writes over the bus hub device port.
//  Autonomously scans it to the panel with binary-coded-modulation (BCM) colour depth.
//  Sits as one device on bus_hub_2_pl (or a wider hub) beside program memory.
// PARAMETERS
//  BASE_ADDR  32'h0010_0000  byte base of the decoded window
//  COLS       64             panel columns (pixels shifted per row)
//  ROWS       64             panel rows; ROWS/2 scan rows; power of 2, >=4
//  BPC        4              bits per colour channel (BCM planes)
//  CLK_DIV    2              core cycles per hub75_clk half-period (>=1)
//  ON_BASE    8              core cycles OE is asserted for plane 0
// PORTS
//  clk          in   1      core clock
//  rst          in   1      synchronous, active-high reset
//  addr         in   32     bus byte address
//  wdata        in   32     bus write data
//  wmask        in   4      byte-lane write enables
//  ren          in   1      read request
//  wen          in   1      write request
//  rdata        out  32     read data
//  ready        out  1      request completed
//  active       out  1      addr decodes to this block (combinational)
//  hub75_rgb0   out  3      {B0,G0,R0}, top-half pixel bit
//  hub75_rgb1   out  3      {B1,G1,R1}, bottom-half pixel bit
//  hub75_addr   out  log2(ROWS/2)  row select {E..A}
//  hub75_clk    out  1      shift clock
//  hub75_stb    out  1      latch strobe, active high
//  hub75_oe     out  1      output enable, active LOW (1 = blank)
// BEHAVIOUR
//  Map
//  - FB_BYTES = 4*ROWS*COLS.
//  - Pixel (x,y) is the 32b word at BASE+4*(y*COLS+x). R=[BPC-1:0], G=[2BPC-1:BPC], B=[3BPC-1:2BPC].
//    Upper bits read 0 and are not stored.
//  - CTRL   BASE+FB_BYTES:   bit0 enable, R/W; others read 0.
//  - STATUS BASE+FB_BYTES+4: [15:0] frame count, RO (writes ignored), wraps 16'hFFFF->0.
//  - active = addr in [BASE, BASE+FB_BYTES+8). Bits [1:0] ignored.
//  Bus
//  - ready <= (ren|wen)&active each cycle: 1-cycle latency, 1-cycle pulse, back-to-back allowed.
//  - rdata is registered with ready; 0 when the request is not active.
//  - Writes apply wmask per byte lane. ren&wen together: the write is performed, rdata = old value.
//  - FB is two dual-port RAMs: top rows 0..ROWS/2-1 and bottom rows. The bus port never stalls the scanner.
//  Scanner FSM: IDLE, FETCH, SHIFT, LATCH, SHOW. Counters row r, plane p, column x.
//  - IDLE: oe=1, clk=0, stb=0. When enable=1 -> FETCH with r=0, p=0.
//  - FETCH (1 cycle): read column 0 of row r (top) and r+ROWS/2 (bottom).
//  - SHIFT: per column 2*CLK_DIV cycles.
//    - rgb0/rgb1 = bit p of each channel; they change only on entry to the low phase.
//    - hub75_clk low CLK_DIV cycles, then high CLK_DIV cycles.
//    - Next column is prefetched. After column COLS-1 high phase -> LATCH.
//  - LATCH: hub75_addr<=r at entry; stb=1 for CLK_DIV cycles; clk=0.
//  - SHOW: oe=0 for ON_BASE<<p cycles, then oe=1. Step to the next plane or row:
//    - p<BPC-1: p++.
//    - else p=0, r++; r wrap to 0 increments the frame count.
//    - Then -> FETCH.
//  - oe=1 in every state except SHOW.
//  - Cycles per (row,plane) = 1 + 2*CLK_DIV*COLS + CLK_DIV + (ON_BASE<<p).
//  - enable cleared mid-scan: the next cycle goes to IDLE, oe=1, clk=0, stb=0. r,p reset to 0; frame count kept.
//  - Bus write to the FB during scan is legal (tearing accepted).
//  Reset
//  - Outputs: rdata=0, ready=0, rgb0=rgb1=0, hub75_addr=0, clk=0, stb=0, oe=1.
//  - State: enable=0, frame count 0, FSM IDLE. FB contents undefined.
// TESTING
//  1 rst held 3 cycles mid-SHOW -> next cycle oe=1, stb=0, clk=0, ready=0, STATUS reads 0, CTRL 0.
//  2 wen BASE+4*5, wdata 32'hDEAD0ABC, wmask 4'b0011; ren same addr -> ready 1 cycle after each;
//    rdata=32'h00000ABC (BPC=4).
//  3 COLS=4,ROWS=4,BPC=2,CLK_DIV=1,ON_BASE=2:
//    px(1,0)=R3, px(1,2)=G2, enable -> plane0 col1 rgb0=3'b001, rgb1=3'b000; plane1 col1 rgb0=3'b001, rgb1=3'b010.
//  4 Same cfg: count cycles -> SHOW oe=0 lasts 2 then 4 cycles; one (row,plane) = 1+8+1+2 = 12 cycles;
//    frame count 1 after 2*(12+14) = 52 cycles from FETCH.
//  5 Clear enable during SHIFT -> next cycle IDLE, oe=1. Re-enable -> first LATCH drives hub75_addr=0.
//  6 ren at BASE+FB_BYTES+8 and BASE-4 -> active=0, ready stays 0.
//    wen to STATUS -> ready=1, count unchanged.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - bus-mapped HUB75 panel controller with frame buffer and BCM scanner
// The CPU owns the frame buffer through the bus port; the scanner reads it on a second port.
module hub75_scan_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
   parameter int          COLS      = 64,
   parameter int          ROWS      = 64,
   parameter int          BPC       = 4,
   parameter int          CLK_DIV   = 2,
   parameter int          ON_BASE   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   addr,
   input  logic [31:0]                   wdata,
   input  logic [3:0]                    wmask,
   input  logic                          ren,
   input  logic                          wen,
   output logic [31:0]                   rdata,
   output logic                          ready,
   output logic                          active,
   output logic [2:0]                    hub75_rgb0,
   output logic [2:0]                    hub75_rgb1,
   output logic [$clog2(ROWS/2)-1:0]     hub75_addr,
   output logic                          hub75_clk,
   output logic                          hub75_stb,
   output logic                          hub75_oe
);

   localparam int HALF     = ROWS / 2;
   localparam int AW       = $clog2(HALF);
   localparam int DEPTH    = HALF * COLS;
   localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PW       = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int PXW      = 3 * BPC;
   localparam int FB_WORDS = ROWS * COLS;
   localparam int SHOW_MAX = ON_BASE << (BPC - 1);
   localparam int CNT_MAX  = (SHOW_MAX > 2 * CLK_DIV) ? SHOW_MAX : 2 * CLK_DIV;
   localparam int CNTW     = $clog2(CNT_MAX + 1);

   localparam logic [CNTW-1:0] DIV_LAST = CNTW'(CLK_DIV - 1);
   localparam logic [CNTW-1:0] PH_LAST  = CNTW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
   localparam logic [AW-1:0]   R_LAST   = AW'(HALF - 1);
   localparam logic [PW-1:0]   P_LAST   = PW'(BPC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_LATCH,
      S_SHOW
   } state_t;

   // ---------------- bus decode ----------------
   logic [29:0]    widx;
   logic           in_top;
   logic           in_bot;
   logic           is_ctrl;
   logic           is_stat;
   logic           req;
   logic [IW-1:0]  top_idx;
   logic [IW-1:0]  bot_idx;
   logic [PXW-1:0] wbits;
   logic           unused_bits;

   assign widx    = addr[31:2] - BASE_ADDR[31:2];
   assign in_top  = widx < 30'(DEPTH);
   assign in_bot  = (widx >= 30'(DEPTH)) && (widx < 30'(FB_WORDS));
   assign is_ctrl = widx == 30'(FB_WORDS);
   assign is_stat = widx == 30'(FB_WORDS + 1);
   assign active  = widx < 30'(FB_WORDS + 2);
   assign req     = (ren || wen) && active;
   assign top_idx = IW'(widx);
   assign bot_idx = IW'(widx - 30'(DEPTH));
   assign unused_bits = ^{addr[1:0], wdata, wmask};

   always_comb begin
      wbits = '0;
      for (int i = 0; i < PXW; i++) begin
         wbits[i] = wmask[i / 8];
      end
   end

   // ---------------- frame buffer: bus port + scanner read port ----------------
   logic [PXW-1:0] fb_top [DEPTH];
   logic [PXW-1:0] fb_bot [DEPTH];

   always_ff @(posedge clk) begin
      if (wen && in_top) begin
         fb_top[top_idx] <= (fb_top[top_idx] & ~wbits) | (wdata[PXW-1:0] & wbits);
      end
      if (wen && in_bot) begin
         fb_bot[bot_idx] <= (fb_bot[bot_idx] & ~wbits) | (wdata[PXW-1:0] & wbits);
      end
   end

   // ---------------- register state ----------------
   state_t          state_q, state_d;
   logic [AW-1:0]   r_q, r_d;
   logic [PW-1:0]   p_q, p_d;
   logic [CW-1:0]   col_q, col_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [15:0]     frame_q, frame_d;
   logic            en_q, en_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic [2:0]      rgb0_q, rgb0_d;
   logic [2:0]      rgb1_q, rgb1_d;
   logic [AW-1:0]   haddr_q, haddr_d;

   // Reads return the pre-write value, so a combined ren&wen sees old data.
   always_comb begin
      rdata_d = '0;
      ready_d = req;
      en_d    = en_q;
      if (req) begin
         if (in_top) begin
            rdata_d = 32'(fb_top[top_idx]);
         end else if (in_bot) begin
            rdata_d = 32'(fb_bot[bot_idx]);
         end else if (is_ctrl) begin
            rdata_d = {31'd0, en_q};
         end else if (is_stat) begin
            rdata_d = {16'd0, frame_q};
         end
      end
      if (wen && is_ctrl && wmask[0]) begin
         en_d = wdata[0];
      end
   end

   // ---------------- scanner ----------------
   function automatic logic [2:0] plane_bits(input logic [PXW-1:0] px, input logic [PW-1:0] p);
      return {px[2 * BPC + int'(p)], px[BPC + int'(p)], px[int'(p)]};
   endfunction

   logic [CW-1:0]   ld_col;
   logic [IW-1:0]   scan_idx;
   logic [CNTW-1:0] show_last;

   // The column being loaded is 0 in FETCH, otherwise the one after the current column.
   assign ld_col    = (state_q == S_FETCH) ? '0 : col_q + CW'(1);
   assign scan_idx  = IW'(r_q) * IW'(COLS) + IW'(ld_col);
   assign show_last = (CNTW'(ON_BASE) << p_q) - CNTW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         p_q     <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         en_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         rgb0_q  <= '0;
         rgb1_q  <= '0;
         haddr_q <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         p_q     <= p_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         en_q    <= en_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         rgb0_q  <= rgb0_d;
         rgb1_q  <= rgb1_d;
         haddr_q <= haddr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      p_d     = p_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      rgb0_d  = rgb0_q;
      rgb1_d  = rgb1_q;
      haddr_d = haddr_q;
      if (!en_d) begin
         state_d = S_IDLE;
         r_d     = '0;
         p_d     = '0;
         col_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
               r_d     = '0;
               p_d     = '0;
               col_d   = '0;
               cnt_d   = '0;
            end
            S_FETCH: begin
               rgb0_d  = plane_bits(fb_top[scan_idx], p_q);
               rgb1_d  = plane_bits(fb_bot[scan_idx], p_q);
               col_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
            S_SHIFT: begin
               if (cnt_q == PH_LAST) begin
                  cnt_d = '0;
                  if (col_q == COL_LAST) begin
                     haddr_d = r_q;
                     state_d = S_LATCH;
                  end else begin
                     col_d  = col_q + CW'(1);
                     rgb0_d = plane_bits(fb_top[scan_idx], p_q);
                     rgb1_d = plane_bits(fb_bot[scan_idx], p_q);
                  end
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            S_LATCH: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_d   = '0;
                  state_d = S_SHOW;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            S_SHOW: begin
               if (cnt_q == show_last) begin
                  cnt_d   = '0;
                  state_d = S_FETCH;
                  if (p_q == P_LAST) begin
                     p_d = '0;
                     if (r_q == R_LAST) begin
                        r_d     = '0;
                        frame_d = frame_q + 16'd1;
                     end else begin
                        r_d = r_q + AW'(1);
                     end
                  end else begin
                     p_d = p_q + PW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      hub75_clk = (state_q == S_SHIFT) && (cnt_q > DIV_LAST);
      hub75_stb = (state_q == S_LATCH);
      hub75_oe  = (state_q != S_SHOW);
   end

   assign rdata      = rdata_q;
   assign ready      = ready_q;
   assign hub75_rgb0 = rgb0_q;
   assign hub75_rgb1 = rgb1_q;
   assign hub75_addr = haddr_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - scoreboard bench for hub75_scan_ctrl on a 4x4 panel, 2 planes
module tb_hub75_scan_ctrl;

   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam logic [31:0] CTRL = BASE + 32'd64;
   localparam logic [31:0] STAT = BASE + 32'd68;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   logic        ren = 1'b0;
   logic        wen = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic        active;
   logic [2:0]  rgb0;
   logic [2:0]  rgb1;
   logic [0:0]  haddr;
   logic        hclk;
   logic        hstb;
   logic        hoe;

   hub75_scan_ctrl #(
      .BASE_ADDR(BASE), .COLS(4), .ROWS(4), .BPC(2), .CLK_DIV(1), .ON_BASE(2)
   ) u_dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
      .ren(ren), .wen(wen), .rdata(rdata), .ready(ready), .active(active),
      .hub75_rgb0(rgb0), .hub75_rgb1(rgb1), .hub75_addr(haddr),
      .hub75_clk(hclk), .hub75_stb(hstb), .hub75_oe(hoe)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        chk;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [5:0] rgb_q[$];
   logic [5:0] rgb_e;
   int         rgb_n = 0;
   logic       prev_hclk = 1'b0;
   int         cyc = 0;
   int         run = 0;
   logic       prev_oe = 1'b1;
   int         fall_q[$];
   int         len_q[$];
   logic [31:0] pix [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus response monitor
   always @(negedge clk) begin
      if (!rst && ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected ready: got 1 expected 0");
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check(mon_e.name, rdata, mon_e.data);
         end
      end
   end

   // Shifted-pixel monitor: first high sample of each hub75_clk pulse
   always @(negedge clk) begin
      if (!rst && hclk && !prev_hclk && rgb_q.size() > 0) begin
         rgb_e = rgb_q.pop_front();
         check($sformatf("rgb shift %0d", rgb_n), {26'd0, rgb0, rgb1}, {26'd0, rgb_e});
         rgb_n++;
      end
      prev_hclk = hclk;
   end

   // OE monitor: cycle of each fall and length of each low run
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_oe = 1'b1;
         run = 0;
      end else begin
         if (!hoe && prev_oe) begin
            fall_q.push_back(cyc);
            run = 0;
         end
         if (!hoe) run++;
         if (hoe && !prev_oe) len_q.push_back(run);
         prev_oe = hoe;
      end
   end

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic r, input logic w, input logic exp_act,
                      input logic chk, input logic [31:0] exp_d, input string name);
      @(posedge clk); #1;
      addr = a; wdata = d; wmask = m; ren = r; wen = w;
      #1;
      check({name, " active"}, {31'd0, active}, {31'd0, exp_act});
      if (exp_act) sb_q.push_back('{chk, exp_d, name});
      @(posedge clk); #1;
      ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
      check({name, " ready"}, {31'd0, ready}, {31'd0, exp_act});
      @(posedge clk); #1;
      check({name, " drained"}, sb_q.size(), 0);
   endtask

   task automatic wait_cond(input int sel, input int max, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         case (sel)
            0: ok = (hoe == 1'b0);
            1: ok = (hstb == 1'b1 && haddr == 1'b0);
            2: ok = (hstb == 1'b1 && haddr == 1'b1);
            3: ok = (hclk == 1'b1);
            4: ok = (len_q.size() >= 4);
            default: ok = (hstb == 1'b1);
         endcase
         if (ok) break;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout %s: got none expected event", name);
      end
   endtask

   function automatic logic [2:0] bits(input logic [31:0] w, input int p);
      return {w[4 + p], w[2 + p], w[p]};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int hc;
      for (int i = 0; i < 16; i++) pix[i] = 32'h0;
      pix[1]  = 32'h03;   // px(1,0) R=3
      pix[7]  = 32'h10;   // px(3,1) B=1
      pix[9]  = 32'h08;   // px(1,2) G=2
      pix[12] = 32'h3F;   // px(0,3) white

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst rdata", rdata, 0);
      check("rst ready", {31'd0, ready}, 0);
      check("rst rgb", {26'd0, rgb0, rgb1}, 0);
      check("rst addr", {31'd0, haddr}, 0);
      check("rst pins", {29'd0, hclk, hstb, hoe}, 32'h1);
      bus(CTRL, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "ctrl rst");
      bus(STAT, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "stat rst");

      for (int i = 0; i < 16; i++)
         bus(BASE + 32'(4 * i), pix[i] | 32'hABCD_0000, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, "fb fill");
      bus(BASE + 32'd4, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h03, "rd px1 upper dropped");
      bus(BASE + 32'd36, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08, "rd px9 bottom");

      bus(BASE + 32'd20, 32'hDEAD0ABC, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 0, "wmask wr");
      bus(BASE + 32'd20, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3C, "wmask rd");
      bus(BASE + 32'd20, 0, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 0, "lane1-3 wr");
      bus(BASE + 32'd20, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3C, "lane1-3 rd");
      bus(BASE + 32'd20, 32'h15, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3C, "rw old");
      bus(BASE + 32'd20, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h15, "rw new");
      pix[5] = 32'h15;

      bus(BASE + 32'd72, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "past end");
      bus(BASE - 32'd4, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "below base");
      bus(STAT + 32'd3, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "stat low bits");
      bus(STAT, 32'hFFFF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, "stat wr");
      bus(STAT, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "stat ro");

      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 2; p++)
            for (int x = 0; x < 4; x++)
               rgb_q.push_back({bits(pix[r * 4 + x], p), bits(pix[(r + 2) * 4 + x], p)});

      bus(CTRL, 1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "enable");
      bus(CTRL, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, "ctrl en rd");
      wait_cond(4, 200, "first frame");
      if (len_q.size() >= 4 && fall_q.size() >= 4) begin
         check("show p0 r0", len_q[0], 2);
         check("show p1 r0", len_q[1], 4);
         check("show p0 r1", len_q[2], 2);
         check("show p1 r1", len_q[3], 4);
         check("period p0", fall_q[1] - fall_q[0], 12);
         check("period p1", fall_q[2] - fall_q[1], 14);
         check("period p0 r1", fall_q[3] - fall_q[2], 12);
      end
      check("all shifts seen", rgb_q.size(), 0);
      bus(STAT, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, "frame count 1");

      wait_cond(1, 200, "row0 latch");
      wait_cond(2, 200, "row1 latch");
      wait_cond(3, 200, "row1 shift");
      @(posedge clk); #1;
      addr = CTRL; wdata = 0; wmask = 4'h1; wen = 1'b1;
      sb_q.push_back('{1'b0, 32'h0, "disable"});
      @(posedge clk); #1;
      wen = 1'b0; addr = '0; wmask = '0;
      check("disable idle", {29'd0, hclk, hstb, hoe}, 32'h1);
      hc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (hclk || hstb || !hoe) hc++;
      end
      check("stays idle", hc, 0);
      bus(STAT, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, "count kept");
      bus(CTRL, 1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "reenable");
      wait_cond(5, 200, "relatch");
      check("relatch addr", {31'd0, haddr}, 0);

      wait_cond(0, 200, "show for reset");
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("mid-show rst pins", {29'd0, hclk, hstb, hoe}, 32'h1);
      check("mid-show rst ready", {31'd0, ready}, 0);
      check("mid-show rst rdata", rdata, 0);
      bus(STAT, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "stat after rst");
      bus(CTRL, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, "ctrl after rst");
      check("sb empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
